quant_packer: RTL and testbench
===============================

QUANT_PACKER -- requirements
Module: quant_packer

Interface
REQ-001 SHALL have parameter FIFO_D, default 4: output FIFO depth in 128-bit words, power of two, 2..16.
REQ-002 SHALL have parameter OUT_W, default `DATA8_W*`VL (128): output word width.
REQ-003 SHALL have ports i_clk in 1 (single clock) and i_rst_n in 1. Reset is asynchronous and active-low.
REQ-004 SHALL have port i_mode in 2: `INT8 / `INT4 / `INT4_VSQ, sampled every cycle.
REQ-005 SHALL have port i_we in 1: quantized beat valid. No stall is available upstream.
REQ-006 SHALL have port i_data in `DATA8_W*`VL: quantized lanes. INT4 modes use only bits [`DATA4_W*`VL-1:0].
REQ-007 SHALL have ports i_vec_done in 1 (marks last beat of a VSQ vector) and i_finish in 1 (pulse one cycle after the last beat of a matrix).
REQ-008 SHALL have ports i_sf_vsq in `TRUNC_W*`VL, i_sf_int4 in `TRUNC_W and i_sf_int8 in `TRUNC_W: scale factors.
REQ-009 SHALL have ports o_valid out 1, i_ready in 1 and o_data out OUT_W: packed output stream.
REQ-010 SHALL have port o_last out 1: qualifies the final word of a matrix.
REQ-011 SHALL have ports o_sf_valid out 1 (one-cycle pulse) and o_sf_data out `TRUNC_W*`VL: scale-factor sideband.
REQ-012 SHALL have ports o_overflow out 1 and o_mode_err out 1: sticky error flags.

Function
REQ-013 SHALL pack INT8 beats as one beat per 128-bit word: o_data = i_data.
REQ-014 SHALL pack INT4 and INT4_VSQ beats two per word: the first beat goes to [63:0] and sets half_pending; the second beat goes to [127:64] and completes the word.
REQ-015 SHALL hold each completed word in a one-word staging register (stage_valid) instead of pushing it to the FIFO directly.
REQ-016 SHALL push the staged word with last=0 when a new word completes. The new word then replaces it in stage the same cycle.
REQ-017 SHALL, when i_finish=1 and half_pending=1, zero-pad the pending half into [127:64]. It SHALL push the staged word (last=0) if present, then push the padded word (last=1) on the next cycle.
REQ-018 SHALL, when i_finish=1 and half_pending=0 with a word staged, push the staged word with last=1.
REQ-019 SHALL, when i_finish=1 and there is no staged word and no pending half, push nothing.
REQ-020 SHALL clear half_pending and stage_valid after a finish flush.
REQ-021 SHALL make at most one FIFO push per cycle. A completing beat that coincides with a pending flush push SHALL wait in a second staging slot. Two-slot staging suffices because i_we is low in the cycle of i_finish.
REQ-022 SHALL treat an INT8 beat arriving with half_pending=1 as a mode error: discard the pending half, set o_mode_err, and process the INT8 beat normally.
REQ-023 SHALL implement the FIFO as FIFO_D entries of {last, data}.
REQ-024 SHALL pop on o_valid && i_ready, with o_valid = !empty and o_data/o_last taken from the head entry.
REQ-025 SHALL make a pushed word visible at the head no earlier than the cycle after the push (no bypass).
REQ-026 SHALL, when full with a simultaneous push and pop, accept the push (count unchanged).
REQ-027 SHALL, when full with a push and no pop, drop the word and set o_overflow. The FIFO contents SHALL remain unchanged.
REQ-028 SHALL wrap read and write pointers modulo FIFO_D and keep the count in 0..FIFO_D.
REQ-029 SHALL, in INT4_VSQ mode with i_vec_done=1 and i_we=1, register o_sf_data <= i_sf_vsq and assert o_sf_valid for one cycle.
REQ-030 SHALL, on i_finish in INT4 mode, register o_sf_data <= {zeros, i_sf_int4} and pulse o_sf_valid.
REQ-031 SHALL, on i_finish in INT8 mode, register o_sf_data <= {zeros, i_sf_int8} and pulse o_sf_valid.
REQ-032 SHALL ignore i_vec_done outside INT4_VSQ mode.
REQ-033 SHALL keep o_overflow and o_mode_err set once asserted, until reset.

Reset
REQ-034 SHALL, on i_rst_n low at any time (including mid-packing), immediately clear FIFO pointers and count, half_pending, stage_valid, o_valid, o_last, o_sf_valid, o_sf_data, o_overflow and o_mode_err to 0. o_data SHALL read 0.
REQ-035 SHALL lose any partial or staged word on reset, with no flush.

Verification
REQ-036 SHALL cover INT8 mode: 3 beats (0x01.., 0x02.., 0x03..), then i_finish, with i_ready=1 -> 3 words in order, o_last=1 only on the third, and o_sf_data[17:0]=i_sf_int8.
REQ-037 SHALL cover INT4 mode: 3 beats A, B, C, then i_finish -> word0 = {B, A} with last=0 and word1 = {0, C} with last=1.
REQ-038 SHALL cover INT4_VSQ mode: i_vec_done with sf_vsq=S on beat 4 -> o_sf_valid pulses once, the cycle after beat 4, with o_sf_data=S.
REQ-039 SHALL cover FIFO_D=4 with i_ready=0 for 6 INT8 beats -> 4 words retained, o_overflow=1; releasing i_ready then yields exactly the first 4 words.
REQ-040 SHALL cover INT4 beat, then INT8 beat -> o_mode_err=1 and one word equal to the INT8 beat.
REQ-041 SHALL cover reset asserted with 2 words queued and a half pending -> o_valid=0 immediately; after release, a fresh INT4 pair packs correctly from [63:0].

Source files
------------

// File: rtl/quant_packer.sv
// quant_packer: packs INT8/INT4 quantized beats into 128-bit words,
// holds one word back to mark the matrix end, and queues words in a FIFO.
`ifndef DATA8_W
`define DATA8_W 8
`endif
`ifndef DATA4_W
`define DATA4_W 4
`endif
`ifndef VL
`define VL 16
`endif
`ifndef TRUNC_W
`define TRUNC_W 18
`endif
`ifndef INT8
`define INT8 2'd0
`endif
`ifndef INT4
`define INT4 2'd1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd2
`endif

module quant_packer #(
   parameter int FIFO_D = 4,
   parameter int OUT_W  = `DATA8_W*`VL
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [1:0]                 i_mode,
   input  logic                       i_we,
   input  logic [`DATA8_W*`VL-1:0]    i_data,
   input  logic                       i_vec_done,
   input  logic                       i_finish,
   input  logic [`TRUNC_W*`VL-1:0]    i_sf_vsq,
   input  logic [`TRUNC_W-1:0]        i_sf_int4,
   input  logic [`TRUNC_W-1:0]        i_sf_int8,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [OUT_W-1:0]           o_data,
   output logic                       o_last,
   output logic                       o_sf_valid,
   output logic [`TRUNC_W*`VL-1:0]    o_sf_data,
   output logic                       o_overflow,
   output logic                       o_mode_err
);

   localparam int HW   = OUT_W / 2;
   localparam int AW   = $clog2(FIFO_D);
   localparam int SF_W = `TRUNC_W*`VL;
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_D);

   logic             is_int4;
   logic             word_done;
   logic [OUT_W-1:0] word;
   logic             half_pending;
   logic [HW-1:0]    half_data;
   logic             stage_valid;
   logic [OUT_W-1:0] stage_data;
   logic             flush_valid;
   logic [OUT_W-1:0] flush_data;
   logic             push;
   logic             push_last;
   logic [OUT_W-1:0] push_data;
   logic             push_ok;
   logic             pop;
   logic             full;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [OUT_W-1:0] mem_data [FIFO_D];
   logic [FIFO_D-1:0] mem_last;

   assign is_int4   = (i_mode == `INT4) || (i_mode == `INT4_VSQ);
   assign word_done = i_we && (!is_int4 || half_pending);
   assign word      = is_int4 ? {i_data[HW-1:0], half_data}
                              : i_data[OUT_W-1:0];

   // The padded flush word gets its own slot so the staged word can go first.
   always_comb begin
      push      = 1'b0;
      push_last = 1'b0;
      push_data = stage_data;
      if (flush_valid) begin
         push      = 1'b1;
         push_last = 1'b1;
         push_data = flush_data;
      end else if (i_finish) begin
         if (stage_valid) begin
            push      = 1'b1;
            push_last = !half_pending;
         end else if (half_pending) begin
            push      = 1'b1;
            push_last = 1'b1;
            push_data = {{HW{1'b0}}, half_data};
         end
      end else if (word_done && stage_valid) begin
         push = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         half_pending <= 1'b0;
         half_data    <= '0;
         stage_valid  <= 1'b0;
         stage_data   <= '0;
         flush_valid  <= 1'b0;
         flush_data   <= '0;
         o_mode_err   <= 1'b0;
      end else begin
         flush_valid <= 1'b0;
         if (i_we) begin
            if (is_int4) begin
               half_pending <= !half_pending;
               if (!half_pending) half_data <= i_data[HW-1:0];
            end else if (half_pending) begin
               half_pending <= 1'b0;
               o_mode_err   <= 1'b1;
            end
         end
         if (word_done) begin
            stage_valid <= 1'b1;
            stage_data  <= word;
         end
         if (i_finish) begin
            half_pending <= 1'b0;
            stage_valid  <= 1'b0;
            flush_valid  <= stage_valid && half_pending;
            flush_data   <= {{HW{1'b0}}, half_data};
         end
      end
   end

   assign o_valid = (count != '0);
   assign full    = (count == DEPTH);
   assign pop     = o_valid && i_ready;
   assign push_ok = push && (!full || pop);
   assign o_data  = o_valid ? mem_data[rd_ptr] : '0;
   assign o_last  = o_valid && mem_last[rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push && !push_ok) o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_data[wr_ptr] <= push_data;
         mem_last[wr_ptr] <= push_last;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_sf_valid <= 1'b0;
         o_sf_data  <= '0;
      end else begin
         o_sf_valid <= 1'b0;
         unique case (1'b1)
            (i_we && i_vec_done && i_mode == `INT4_VSQ): begin
               o_sf_valid <= 1'b1;
               o_sf_data  <= i_sf_vsq;
            end
            (i_finish && i_mode == `INT4): begin
               o_sf_valid <= 1'b1;
               o_sf_data  <= {{(SF_W-`TRUNC_W){1'b0}}, i_sf_int4};
            end
            (i_finish && i_mode == `INT8): begin
               o_sf_valid <= 1'b1;
               o_sf_data  <= {{(SF_W-`TRUNC_W){1'b0}}, i_sf_int8};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quant_packer.sv
// tb_quant_packer: randomized and directed stimulus against a packing
// model, with scoreboards for the word stream and scale-factor sideband.
`ifndef DATA8_W
`define DATA8_W 8
`endif
`ifndef DATA4_W
`define DATA4_W 4
`endif
`ifndef VL
`define VL 16
`endif
`ifndef TRUNC_W
`define TRUNC_W 18
`endif
`ifndef INT8
`define INT8 2'd0
`endif
`ifndef INT4
`define INT4 2'd1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd2
`endif

module tb_quant_packer;

   localparam int FD  = 4;
   localparam int W   = 128;
   localparam int HW  = 64;
   localparam int SW  = `TRUNC_W;
   localparam int SFA = `TRUNC_W*`VL;
   localparam logic [1:0] M8  = `INT8;
   localparam logic [1:0] M4  = `INT4;
   localparam logic [1:0] MV  = `INT4_VSQ;

   typedef struct {
      logic         last;
      logic [W-1:0] data;
   } word_t;

   typedef struct {
      logic [SFA-1:0] data;
      int             cyc;
   } sf_t;

   typedef struct {
      logic [1:0]     mode;
      logic [W-1:0]   data;
      logic           vd;
      logic [SFA-1:0] sfv;
   } beat_t;

   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic [1:0]     i_mode = M8;
   logic           i_we = 1'b0;
   logic [W-1:0]   i_data = '0;
   logic           i_vec_done = 1'b0;
   logic           i_finish = 1'b0;
   logic [SFA-1:0] i_sf_vsq = '0;
   logic [SW-1:0]  i_sf_int4 = '0;
   logic [SW-1:0]  i_sf_int8 = '0;
   logic           o_valid;
   logic           i_ready = 1'b0;
   logic [W-1:0]   o_data;
   logic           o_last;
   logic           o_sf_valid;
   logic [SFA-1:0] o_sf_data;
   logic           o_overflow;
   logic           o_mode_err;

   quant_packer #(.FIFO_D(FD), .OUT_W(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode),
      .i_we(i_we), .i_data(i_data), .i_vec_done(i_vec_done),
      .i_finish(i_finish), .i_sf_vsq(i_sf_vsq),
      .i_sf_int4(i_sf_int4), .i_sf_int8(i_sf_int8),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_last(o_last), .o_sf_valid(o_sf_valid),
      .o_sf_data(o_sf_data), .o_overflow(o_overflow),
      .o_mode_err(o_mode_err)
   );

   always #5 i_clk = ~i_clk;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   bit    ready_rand = 1'b0;
   bit    ready_val = 1'b0;
   bit    exp_err = 1'b0;
   word_t exp_q[$];
   sf_t   sf_q[$];
   beat_t beats[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [511:0] act,
                      input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         i_ready = ready_rand ? ($urandom_range(3) != 0) : ready_val;
      end
   end

   always @(negedge i_clk) begin : mon
      word_t e;
      sf_t   s;
      if (i_rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %0h expected none", o_data);
         end else begin
            e = exp_q.pop_front();
            chk("word_data", o_data, e.data);
            chk("word_last", o_last, e.last);
         end
      end
      if (i_rst_n && o_sf_valid) begin
         if (sf_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_sf: got %0h expected none", o_sf_data);
         end else begin
            s = sf_q.pop_front();
            chk("sf_data", o_sf_data, s.data);
            chk("sf_cycle", cyc, s.cyc);
         end
      end
   end

   function automatic logic [W-1:0] rand_w();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [SFA-1:0] rand_sf();
      logic [SFA-1:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) v = {v[SFA-33:0], 32'($urandom)};
      return v;
   endfunction

   task automatic add_beat(input logic [1:0] m, input logic [W-1:0] d,
                           input logic vd, input logic [SFA-1:0] sfv);
      beat_t b;
      b.mode = m;
      b.data = d;
      b.vd   = vd;
      b.sfv  = sfv;
      beats.push_back(b);
   endtask

   // Packing rules: INT8 = whole word; INT4 beats pair low-then-high;
   // an INT8 beat discards an unpaired half; a leftover half is zero-padded.
   task automatic model(input int keep);
      logic [W-1:0]  ws[$];
      logic          pend;
      logic [HW-1:0] half;
      word_t         e;
      pend = 1'b0;
      half = '0;
      foreach (beats[i]) begin
         if (beats[i].mode == M8) begin
            if (pend) exp_err = 1'b1;
            pend = 1'b0;
            ws.push_back(beats[i].data);
         end else if (pend) begin
            ws.push_back({beats[i].data[HW-1:0], half});
            pend = 1'b0;
         end else begin
            half = beats[i].data[HW-1:0];
            pend = 1'b1;
         end
      end
      if (pend) ws.push_back({{HW{1'b0}}, half});
      foreach (ws[i]) begin
         if (keep < 0 || i < keep) begin
            e.last = (i == ws.size() - 1);
            e.data = ws[i];
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drive(input logic [1:0] fmode, input bit fin,
                        input bit gaps);
      int  g;
      sf_t s;
      foreach (beats[i]) begin
         @(posedge i_clk);
         #1;
         i_we       = 1'b1;
         i_mode     = beats[i].mode;
         i_data     = beats[i].data;
         i_vec_done = beats[i].vd;
         i_sf_vsq   = beats[i].sfv;
         if (beats[i].mode == MV && beats[i].vd) begin
            s.data = beats[i].sfv;
            s.cyc  = cyc + 1;
            sf_q.push_back(s);
         end
         if (gaps && i != beats.size() - 1) begin
            g = $urandom_range(2);
            repeat (g) begin
               @(posedge i_clk);
               #1;
               i_we       = 1'b0;
               i_vec_done = 1'b0;
            end
         end
      end
      @(posedge i_clk);
      #1;
      i_we       = 1'b0;
      i_vec_done = 1'b0;
      if (fin) begin
         i_finish  = 1'b1;
         i_mode    = fmode;
         i_sf_int4 = SW'($urandom);
         i_sf_int8 = SW'($urandom);
         if (fmode == M4 || fmode == M8) begin
            s.data = '0;
            s.data[SW-1:0] = (fmode == M4) ? i_sf_int4 : i_sf_int8;
            s.cyc = cyc + 1;
            sf_q.push_back(s);
         end
         @(posedge i_clk);
         #1;
         i_finish = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || sf_q.size() != 0) && n < 300) begin
         @(posedge i_clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || sf_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d words %0d sf left expected 0",
                  exp_q.size(), sf_q.size());
      end
      repeat (3) @(posedge i_clk);
   endtask

   task automatic rand_matrix();
      logic [1:0] m;
      int         n;
      m = 2'($urandom_range(2));
      n = (m == M8) ? $urandom_range(1, FD) : $urandom_range(1, 2*FD);
      beats.delete();
      for (int k = 0; k < n; k++)
         add_beat(m, rand_w(), ($urandom_range(2) == 0), rand_sf());
      model(-1);
      drive(m, 1'b1, 1'b1);
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] a, b;
      repeat (3) @(posedge i_clk);
      #2;
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_last", o_last, 1'b0);
      chk("rst_data", o_data, '0);
      chk("rst_sf_valid", o_sf_valid, 1'b0);
      chk("rst_sf_data", o_sf_data, '0);
      chk("rst_overflow", o_overflow, 1'b0);
      chk("rst_mode_err", o_mode_err, 1'b0);
      @(negedge i_clk);
      i_rst_n   = 1'b1;
      ready_val = 1'b1;
      repeat (2) @(posedge i_clk);

      beats.delete();
      add_beat(M8, {16{8'h01}}, 1'b0, '0);
      add_beat(M8, {16{8'h02}}, 1'b1, rand_sf());
      add_beat(M8, {16{8'h03}}, 1'b0, '0);
      model(-1);
      drive(M8, 1'b1, 1'b0);
      drain();

      beats.delete();
      for (int k = 0; k < 3; k++) add_beat(M4, rand_w(), 1'b0, '0);
      model(-1);
      drive(M4, 1'b1, 1'b0);
      drain();

      beats.delete();
      for (int k = 0; k < 4; k++)
         add_beat(MV, rand_w(), (k == 3), rand_sf());
      model(-1);
      drive(MV, 1'b1, 1'b0);
      drain();

      beats.delete();
      add_beat(M4, rand_w(), 1'b0, '0);
      add_beat(M8, rand_w(), 1'b0, '0);
      model(-1);
      drive(M8, 1'b1, 1'b0);
      drain();
      chk("mode_err_set", o_mode_err, exp_err);

      ready_val = 1'b0;
      beats.delete();
      for (int k = 0; k < 6; k++) add_beat(M8, rand_w(), 1'b0, '0);
      model(FD);
      drive(M8, 1'b1, 1'b0);
      repeat (2) @(posedge i_clk);
      #2;
      chk("ovf_set", o_overflow, 1'b1);
      chk("ovf_valid", o_valid, 1'b1);
      ready_val = 1'b1;
      drain();
      #2;
      chk("ovf_drained", o_valid, 1'b0);

      ready_rand = 1'b1;
      for (int t = 0; t < 40; t++) rand_matrix();
      ready_rand = 1'b0;
      ready_val  = 1'b0;
      #2;
      chk("sticky_ovf", o_overflow, 1'b1);
      chk("sticky_mode_err", o_mode_err, exp_err);

      beats.delete();
      for (int k = 0; k < 7; k++) add_beat(M4, rand_w(), 1'b0, '0);
      drive(M4, 1'b0, 1'b0);
      repeat (2) @(posedge i_clk);
      #3;
      chk("pre_rst_valid", o_valid, 1'b1);
      i_rst_n = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("async_rst_valid", o_valid, 1'b0);
      chk("async_rst_data", o_data, '0);
      chk("async_rst_ovf", o_overflow, 1'b0);
      chk("async_rst_err", o_mode_err, 1'b0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n   = 1'b1;
      ready_val = 1'b1;
      a = rand_w();
      b = rand_w();
      beats.delete();
      add_beat(M4, a, 1'b0, '0);
      add_beat(M4, b, 1'b0, '0);
      model(-1);
      drive(M4, 1'b1, 1'b0);
      drain();
      #2;
      chk("post_rst_err", o_mode_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
